alu_writeback: RTL
==================

Name: alu_writeback

Overview:
- Execute/writeback stage wrapped around the 4-bit ALU.
- Holds the operand register file that drives ALU inputs A/B, and captures the ALU result and NZCV flags through a valid/ready handshake.
- Commits the result to a destination register and updates the architectural flags register, both gated by a 2-bit condition code.
- Sits between the instruction sequencer (upstream) and the ALU output (consumed here).

Parameters:
- DATA_W, 4, operand/result width (ALU result bus is DATA_W+1).
- NREGS, 4, number of general registers; power of two; address width AW = $clog2(NREGS).
- CNT_W, 8, width of committed-operation counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- rd_addr_a  input  AW  register index driving ALU operand A
- rd_addr_b  input  AW  register index driving ALU operand B
- rd_data_a  output  DATA_W  operand A to ALU (combinational read)
- rd_data_b  output  DATA_W  operand B to ALU (combinational read)
- in_valid  input  1  ALU result/flags and op fields valid this cycle
- in_ready  output  1  stage can accept
- Risultato  input  DATA_W+1  ALU result; bit DATA_W = carry-out
- ALUflags  input  4  bit0 N, bit1 Z, bit2 C, bit3 V
- dest_reg  input  AW  destination register
- cond  input  2  00 always, 01 EQ (Z=1), 10 NE (Z=0), 11 MI (N=1)
- set_flags  input  1  update flags register on commit
- flags_q  output  4  architectural flags, same bit order as ALUflags
- commit_valid  output  1  one-cycle pulse: an op committed this cycle (cond passed)
- op_count  output  CNT_W  number of committed ops

Behaviour:
- Reset (asynchronous, rst_n=0): all registers 0, flags_q=0, pending stage empty, commit_valid=0, op_count=0. in_ready=1 once rst_n is released.
- Accept: on a rising edge with in_valid & in_ready, capture Risultato[DATA_W-1:0], ALUflags, dest_reg, cond and set_flags into the pending register; pend_v=1.
- Commit cycle: the cycle in which pend_v=1.
  - Evaluate cond against flags_q. This already includes every earlier committed op, so there is no flag hazard.
  - Pass: at the closing edge, write the pending result to regs[dest]; if set_flags, flags_q <= pending flags; commit_valid=1 during that cycle; op_count += 1, wrapping to 0 after all-ones.
  - Fail: no register, flag or counter update; commit_valid=0.
  - pend_v clears at the edge unless a new op is accepted on the same edge, which replaces it.
- Latency: accept edge E, architectural state visible after edge E+1.
- Result bit DATA_W (carry-out) is never written to a register; carry is visible only through the C flag.
- Reads: combinational from the register file. Both ports may address the same register.
- Reset mid-operation: pending op is discarded and not committed.
- in_valid while in_ready=0: ignored. The upstream block holds its fields until accepted.

Optional Feature:
- FORWARD_EN defined:
  - in_ready is constantly 1, so back-to-back accepts are allowed.
  - rd_data_a/b return the pending result when pend_v, cond passes, and the read address equals the pending dest. Otherwise they return the register value.
- FORWARD_EN undefined:
  - No bypass path.
  - in_ready = ~pend_v, giving at most one accept every two cycles; reads therefore always see committed state.

Decomposition:
- Package alu_pkg holds:
  - cond_e enum (COND_AL, COND_EQ, COND_NE, COND_MI).
  - Flag index constants FLAG_N=0, FLAG_Z=1, FLAG_C=2, FLAG_V=3.
  - Default widths DATA_W, CNT_W.
- One natural sub-module: alu_cond_check, a combinational cond + flags -> pass. It is reused by the sequencer.

Test Plan:
- Reset: assert rst_n=0 mid-commit -> flags_q=0, all regs read 0, op_count=0, commit_valid=0.
- Simple write: accept Risultato=5'b0_0111, flags=0000, dest=2, cond=AL, set_flags=1 -> one cycle later regs[2]=7, flags_q=0000, commit_valid pulse, op_count=1.
- Carry drop: Risultato=5'b1_0000, ALUflags=4'b0110 (Z,C), dest=1, set_flags=1 -> regs[1]=0, flags_q=0110.
- Condition fail: flags_q Z=0, accept cond=EQ, dest=3, Risultato=9 -> regs[3] unchanged, no commit_valid, op_count unchanged. Repeat with cond=NE -> regs[3]=9.
- Back-to-back (FORWARD_EN): op1 writes regs[0]=4, op2 accepted the next cycle reading rd_addr_a=0 -> rd_data_a=4 before op1 commits. Without FORWARD_EN, in_ready=0 in that cycle.
- Counter wrap: 256 committed ops with CNT_W=8 -> op_count returns to 0; ops failing cond are not counted.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU execute/writeback slice:
// condition-code encoding, NZCV flag bit positions and default widths.
package alu_pkg;

    localparam int DATA_W = 4;
    localparam int CNT_W  = 8;

    localparam int FLAG_N = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [1:0] {
        COND_AL = 2'b00,
        COND_EQ = 2'b01,
        COND_NE = 2'b10,
        COND_MI = 2'b11
    } cond_e;

endpackage

// File: rtl/alu_cond_check.sv
// Combinational condition-code evaluator: decides whether an op guarded by
// cond may commit given the current NZCV flags.
module alu_cond_check
    import alu_pkg::*;
(
    input  cond_e      cond,
    input  logic [3:0] flags,
    output logic       pass
);

    always_comb begin
        pass = 1'b0;
        unique case (cond)
            COND_AL: pass = 1'b1;
            COND_EQ: pass = flags[FLAG_Z];
            COND_NE: pass = ~flags[FLAG_Z];
            COND_MI: pass = flags[FLAG_N];
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_writeback.sv
// Execute/writeback stage around the 4-bit ALU: operand register file,
// one-deep pending slot, condition-gated commit of result and flags.
// Optional macro FORWARD_EN: pending result bypassed to reads, in_ready tied high.
module alu_writeback #(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int NREGS  = 4,
    parameter int CNT_W  = alu_pkg::CNT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [$clog2(NREGS)-1:0] rd_addr_a,
    input  logic [$clog2(NREGS)-1:0] rd_addr_b,
    output logic [DATA_W-1:0]        rd_data_a,
    output logic [DATA_W-1:0]        rd_data_b,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W:0]          Risultato,
    input  logic [3:0]               ALUflags,
    input  logic [$clog2(NREGS)-1:0] dest_reg,
    input  logic [1:0]               cond,
    input  logic                     set_flags,
    output logic [3:0]               flags_q,
    output logic                     commit_valid,
    output logic [CNT_W-1:0]         op_count
);

    import alu_pkg::*;

    localparam int AW = $clog2(NREGS);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic              pend_v_q, pend_v_d;
    logic [DATA_W-1:0] pend_res_q;
    logic [3:0]        pend_flags_q;
    logic [AW-1:0]     pend_dest_q;
    cond_e             pend_cond_q;
    logic              pend_set_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept;
    logic              pass;
    logic              commit;

    // The carry-out only reaches architectural state through the C flag.
    logic unused_carry;
    assign unused_carry = Risultato[DATA_W];

    alu_cond_check u_cond (
        .cond  (pend_cond_q),
        .flags (flags_q),
        .pass  (pass)
    );

    assign accept   = in_valid & in_ready;
    assign commit   = pend_v_q & pass;
    assign pend_v_d = accept;
    assign cnt_d    = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            flags_q      <= '0;
            cnt_q        <= '0;
            pend_v_q     <= 1'b0;
            pend_res_q   <= '0;
            pend_flags_q <= '0;
            pend_dest_q  <= '0;
            pend_cond_q  <= COND_AL;
            pend_set_q   <= 1'b0;
        end else begin
            if (commit) begin
                regs_q[pend_dest_q] <= pend_res_q;
                if (pend_set_q) flags_q <= pend_flags_q;
                cnt_q <= cnt_d;
            end
            pend_v_q <= pend_v_d;
            if (accept) begin
                pend_res_q   <= Risultato[DATA_W-1:0];
                pend_flags_q <= ALUflags;
                pend_dest_q  <= dest_reg;
                pend_cond_q  <= cond_e'(cond);
                pend_set_q   <= set_flags;
            end
        end
    end

    assign commit_valid = commit;
    assign op_count     = cnt_q;

`ifdef FORWARD_EN
    assign in_ready = 1'b1;

    // Only a pending op that is about to commit may be bypassed.
    always_comb begin
        rd_data_a = regs_q[rd_addr_a];
        rd_data_b = regs_q[rd_addr_b];
        if (commit && (rd_addr_a == pend_dest_q)) rd_data_a = pend_res_q;
        if (commit && (rd_addr_b == pend_dest_q)) rd_data_b = pend_res_q;
    end
`else
    assign in_ready  = ~pend_v_q;
    assign rd_data_a = regs_q[rd_addr_a];
    assign rd_data_b = regs_q[rd_addr_b];
`endif

endmodule
